// File: rtl/regfile_scan_checker_if.sv
// Bus bundle between the scan checker and its environment (CPU write observation, regfile port A, expected ROM).
interface regfile_scan_checker_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int CYC_W  = 16,
  parameter int ERR_W  = 8
);
  logic              start;
  logic [CYC_W-1:0]  num_cycles;
  logic              verify_en;
  logic              rwe;
  logic [IDX_W-1:0]  rd;
  logic [DATA_W-1:0] reg_data;
  logic [DATA_W-1:0] exp_data;
  logic              run_active;
  logic              test_mode;
  logic [IDX_W-1:0]  test_reg;
  logic [IDX_W-1:0]  exp_addr;
  logic              mismatch;
  logic [IDX_W-1:0]  fail_idx;
  logic [IDX_W-1:0]  first_fail;
  logic [ERR_W-1:0]  err_count;
  logic [ERR_W-1:0]  wr_count;
  logic              done;
  logic              pass;

  modport master (
    output start, num_cycles, verify_en, rwe, rd, reg_data, exp_data,
    input  run_active, test_mode, test_reg, exp_addr, mismatch, fail_idx,
           first_fail, err_count, wr_count, done, pass
  );

  modport slave (
    input  start, num_cycles, verify_en, rwe, rd, reg_data, exp_data,
    output run_active, test_mode, test_reg, exp_addr, mismatch, fail_idx,
           first_fail, err_count, wr_count, done, pass
  );
endinterface

// File: rtl/regfile_scan_checker.sv
// Run-then-check harness: lets the CPU run for a programmed number of cycles counting register writes,
// then scans every register through read port A against an expected-value ROM.
module regfile_scan_checker #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int IDX_W  = 5,
  parameter int CYC_W  = 16,
  parameter int ERR_W  = 8
) (
  input logic clk,
  input logic rst_n,
  regfile_scan_checker_if.slave bus
);
  // state  | meaning
  // IDLE   | waiting for start after reset
  // RUN    | CPU runs, architectural writes counted
  // SET    | index presented to regfile and ROM
  // CMP    | regfile data compared with ROM data
  // DONE   | results held, start re-arms
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SET, S_CMP, S_DONE} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREGS - 1);

  state_t            state_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [CYC_W-1:0]  ncyc_q;
  logic              verify_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ERR_W-1:0]  wr_q;
  logic [IDX_W-1:0]  ff_q;
  logic              pass_q;
  logic              start_ok;
  logic              miscmp;
  logic              scanning;

  assign start_ok = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign scanning = (state_q == S_SET) || (state_q == S_CMP);
  // reg_data is combinational from test_reg and exp_data was captured at the SET edge
  assign miscmp   = (state_q == S_CMP) && verify_q && (bus.reg_data != bus.exp_data);

  always_comb begin
    err_d = err_q;
    if (start_ok)
      err_d = '0;
    else if (miscmp && err_q != ERR_MAX)
      err_d = err_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      ncyc_q   <= '0;
      verify_q <= 1'b0;
      idx_q    <= '0;
      err_q    <= '0;
      wr_q     <= '0;
      ff_q     <= '1;
      pass_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            ncyc_q   <= bus.num_cycles;
            verify_q <= bus.verify_en;
            cyc_q    <= '0;
            idx_q    <= '0;
            wr_q     <= '0;
            ff_q     <= '1;
            pass_q   <= 1'b0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          // a zero-length run still spends one cycle here but counts nothing
          if (ncyc_q != '0 && bus.rwe && bus.rd != '0 && wr_q != ERR_MAX)
            wr_q <= wr_q + ERR_W'(1);
          if (ncyc_q == '0 || cyc_q == ncyc_q - CYC_W'(1)) begin
            idx_q   <= '0;
            state_q <= S_SET;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        S_SET: state_q <= S_CMP;
        S_CMP: begin
          if (miscmp && ff_q == '1 && int'(idx_q) < NREGS)
            ff_q <= idx_q;
          if (idx_q == IDX_LAST) begin
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_SET;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.run_active = (state_q == S_RUN);
  assign bus.test_mode  = scanning;
  assign bus.test_reg   = scanning ? idx_q : '0;
  assign bus.exp_addr   = scanning ? idx_q : '0;
  assign bus.mismatch   = miscmp;
  assign bus.fail_idx   = miscmp ? idx_q : '0;
  assign bus.first_fail = ff_q;
  assign bus.err_count  = err_q;
  assign bus.wr_count   = wr_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.pass       = pass_q;
endmodule

// File: tb/tb_regfile_scan_checker.sv
// Directed bench for regfile_scan_checker: models the regfile read port and a 1-cycle expected-value ROM.
module tb_regfile_scan_checker;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int CW = 16;
  localparam int EW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_scan_checker_if #(.DATA_W(DW), .IDX_W(IW), .CYC_W(CW), .ERR_W(EW)) bus ();

  regfile_scan_checker #(.DATA_W(DW), .NREGS(32), .IDX_W(IW), .CYC_W(CW), .ERR_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] regs [32];
  logic [DW-1:0] rom  [32];

  assign bus.reg_data = regs[bus.test_reg];
  always @(posedge clk) bus.exp_data <= rom[bus.exp_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int run_cnt, scan_cnt;
  bit got_done;
  logic [IW-1:0] fq[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rom_ok;
    for (int i = 0; i < 32; i++) rom[i] = regs[i];
  endtask

  // wr_mode: 0 none, 1 rd=0 for 4 RUN cycles then rd=5 (rd=7 outside RUN), 2 rd=5 always
  task automatic do_run(input logic [CW-1:0] n, input logic v, input int wr_mode, input bit mid_start);
    bus.num_cycles = n;
    bus.verify_en  = v;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    run_cnt = 0; scan_cnt = 0; got_done = 0; fq.delete();
    for (int k = 0; k < 300; k++) begin
      if (bus.done) begin got_done = 1; break; end
      if (bus.run_active) run_cnt++;
      if (bus.test_mode) begin
        scan_cnt++;
        if (bus.mismatch) fq.push_back(bus.fail_idx);
      end
      bus.rwe = (wr_mode != 0);
      if (wr_mode == 1) bus.rd = bus.run_active ? ((run_cnt <= 4) ? 5'd0 : 5'd5) : 5'd7;
      else              bus.rd = 5'd5;
      bus.start = mid_start && bus.test_mode && (scan_cnt == 5);
      tick();
    end
    bus.start = 1'b0;
    bus.rwe   = 1'b0;
    n_checks++;
    if (!got_done) begin n_fail++; $display("FAIL run_timeout: done never rose (got %0b, want 1)", got_done); end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    n_checks++;
    if ({bus.run_active, bus.test_mode, bus.mismatch, bus.done, bus.pass} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.run_active, bus.test_mode, bus.mismatch, bus.done, bus.pass});
    end
    n_checks++;
    if (bus.first_fail !== 5'd31) begin n_fail++; $display("FAIL reset_first_fail: got %0d want 31", bus.first_fail); end
    n_checks++;
    if ({bus.err_count, bus.wr_count, bus.test_reg, bus.fail_idx} !== '0) begin
      n_fail++; $display("FAIL reset_counts: got err=%0d wr=%0d reg=%0d fidx=%0d want 0", bus.err_count, bus.wr_count, bus.test_reg, bus.fail_idx);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_scan;
    rom_ok();
    do_run(16'd10, 1'b1, 0, 1'b0);
    n_checks++; if (run_cnt != 10) begin n_fail++; $display("FAIL t1_run_len: got %0d want 10", run_cnt); end
    n_checks++; if (scan_cnt != 64) begin n_fail++; $display("FAIL t1_scan_len: got %0d want 64", scan_cnt); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL t1_pass: got %b want 1", bus.pass); end
    n_checks++; if (bus.err_count !== 4'd0) begin n_fail++; $display("FAIL t1_err: got %0d want 0", bus.err_count); end
    n_checks++; if (bus.first_fail !== 5'd31) begin n_fail++; $display("FAIL t1_first_fail: got %0d want 31", bus.first_fail); end
    n_checks++; if (fq.size() != 0) begin n_fail++; $display("FAIL t1_strobes: got %0d want 0", fq.size()); end
  endtask

  task automatic test_two_errors;
    logic [IW-1:0] f0, f1;
    rom_ok();
    rom[3]  = rom[3]  ^ 32'h0000_0100;
    rom[17] = rom[17] ^ 32'h8000_0000;
    do_run(16'd6, 1'b1, 0, 1'b0);
    f0 = (fq.size() > 0) ? fq[0] : 5'd31;
    f1 = (fq.size() > 1) ? fq[1] : 5'd31;
    n_checks++; if (fq.size() != 2) begin n_fail++; $display("FAIL t2_strobes: got %0d want 2", fq.size()); end
    n_checks++; if (f0 !== 5'd3 || f1 !== 5'd17) begin n_fail++; $display("FAIL t2_fail_idx: got %0d,%0d want 3,17", f0, f1); end
    n_checks++; if (bus.err_count !== 4'd2) begin n_fail++; $display("FAIL t2_err: got %0d want 2", bus.err_count); end
    n_checks++; if (bus.first_fail !== 5'd3) begin n_fail++; $display("FAIL t2_first_fail: got %0d want 3", bus.first_fail); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL t2_pass: got %b want 0", bus.pass); end
  endtask

  task automatic test_write_count;
    rom_ok();
    do_run(16'd10, 1'b1, 1, 1'b0);
    n_checks++; if (bus.wr_count !== 4'd6) begin n_fail++; $display("FAIL t3_wr_count: got %0d want 6", bus.wr_count); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL t3_pass: got %b want 1", bus.pass); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 32; i++) rom[i] = ~regs[i];
    do_run(16'd3, 1'b1, 0, 1'b0);
    n_checks++; if (bus.err_count !== 4'd15) begin n_fail++; $display("FAIL t4_err_sat: got %0d want 15", bus.err_count); end
    n_checks++; if (fq.size() != 32) begin n_fail++; $display("FAIL t4_strobes: got %0d want 32", fq.size()); end
    n_checks++; if (bus.first_fail !== 5'd0) begin n_fail++; $display("FAIL t4_first_fail: got %0d want 0", bus.first_fail); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL t4_pass: got %b want 0", bus.pass); end
    do_run(16'd3, 1'b0, 0, 1'b0);
    n_checks++; if (bus.err_count !== 4'd0) begin n_fail++; $display("FAIL t4_noverify_err: got %0d want 0", bus.err_count); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL t4_noverify_pass: got %b want 1", bus.pass); end
    n_checks++; if (fq.size() != 0) begin n_fail++; $display("FAIL t4_noverify_strobes: got %0d want 0", fq.size()); end
  endtask

  task automatic test_mid_scan;
    int seen;
    rom_ok();
    rom[0] = rom[0] ^ 32'h1;
    do_run(16'd2, 1'b1, 0, 1'b1);
    n_checks++; if (run_cnt != 2 || scan_cnt != 64) begin n_fail++; $display("FAIL t5_start_ignored: got run=%0d scan=%0d want 2,64", run_cnt, scan_cnt); end
    n_checks++; if (bus.err_count !== 4'd1 || bus.first_fail !== 5'd0) begin n_fail++; $display("FAIL t5_results: got err=%0d ff=%0d want 1,0", bus.err_count, bus.first_fail); end
    bus.num_cycles = 16'd4; bus.verify_en = 1'b1; bus.rwe = 1'b1; bus.rd = 5'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 0;
    for (int k = 0; k < 60 && seen < 10; k++) begin
      if (bus.test_mode) seen++;
      if (seen < 10) tick();
    end
    bus.rwe = 1'b0;
    n_checks++; if (seen != 10) begin n_fail++; $display("FAIL t5_reach_scan: got %0d want 10", seen); end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({bus.run_active, bus.test_mode, bus.mismatch, bus.done, bus.pass} !== 5'b0 ||
        {bus.err_count, bus.wr_count, bus.test_reg, bus.exp_addr} !== '0) begin
      n_fail++; $display("FAIL t5_reset_abort: got tm=%b err=%0d wr=%0d reg=%0d want all 0", bus.test_mode, bus.err_count, bus.wr_count, bus.test_reg);
    end
    n_checks++; if (bus.first_fail !== 5'd31) begin n_fail++; $display("FAIL t5_reset_ff: got %0d want 31", bus.first_fail); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 32; i++) rom[i] = ~regs[i];
    do_run(16'd0, 1'b1, 2, 1'b0);
    n_checks++; if (run_cnt != 1 || scan_cnt != 64) begin n_fail++; $display("FAIL t6_zero_run: got run=%0d scan=%0d want 1,64", run_cnt, scan_cnt); end
    n_checks++; if (bus.wr_count !== 4'd0) begin n_fail++; $display("FAIL t6_zero_wr: got %0d want 0", bus.wr_count); end
    rom_ok();
    bus.num_cycles = 16'd5; bus.verify_en = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.run_active !== 1'b1 || bus.err_count !== 4'd0 || bus.first_fail !== 5'd31) begin
      n_fail++; $display("FAIL t6_restart: got done=%b run=%b err=%0d ff=%0d want 0,1,0,31", bus.done, bus.run_active, bus.err_count, bus.first_fail);
    end
    got_done = 0;
    for (int k = 0; k < 200 && !got_done; k++) begin
      if (bus.done) got_done = 1;
      else tick();
    end
    n_checks++;
    if (!got_done || bus.pass !== 1'b1 || bus.err_count !== 4'd0) begin
      n_fail++; $display("FAIL t6_second_run: got done=%b pass=%b err=%0d want 1,1,0", got_done, bus.pass, bus.err_count);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.num_cycles = '0; bus.verify_en = 1'b0; bus.rwe = 1'b0; bus.rd = '0;
    for (int i = 0; i < 32; i++) regs[i] = (i * 32'h0101_0101) ^ 32'hA5C3_0000 ^ i;
    rom_ok();
    test_reset();
    test_clean_scan();
    test_two_errors();
    test_write_count();
    test_saturate();
    test_mid_scan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
